// File: rtl/bram_flush_writer.sv
// -----------------------------------------------------------------------------
// bram_flush_writer
//
// Front end for a simple dual-port block RAM. It clears the whole memory to
// zero after reset (INIT sweep) and on request (FLUSH sweep). It also passes
// user writes and reads through while idle. During a sweep the memory is
// logically all-zero:
//   - user writes are dropped;
//   - user reads return zero;
//   - flush requests are ignored.
// A read that hits a write in the same idle cycle is forwarded from the write
// data. Without forwarding, the read-first RAM would return the stale word.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   flush_req                request a zero sweep of the whole memory
//   busy                     high while a sweep (INIT or FLUSH) is running
//   usr_we/waddr/wdata       user write port
//   usr_re/raddr             user read port
//   rd_valid/rd_data         read response, one cycle after usr_re
//   mem_ena/wea/addra/dina   memory write port
//   mem_enb/addrb            memory read port
//   mem_doutb                memory read data, 1-cycle registered latency
// -----------------------------------------------------------------------------
module bram_flush_writer #(
  parameter int LEN_DATA = 20,
  parameter int LEN_ADDR = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_req,
  output logic                busy,
  input  logic                usr_we,
  input  logic [LEN_ADDR-1:0] usr_waddr,
  input  logic [LEN_DATA-1:0] usr_wdata,
  input  logic                usr_re,
  input  logic [LEN_ADDR-1:0] usr_raddr,
  output logic                rd_valid,
  output logic [LEN_DATA-1:0] rd_data,
  output logic                mem_ena,
  output logic                mem_wea,
  output logic [LEN_ADDR-1:0] mem_addra,
  output logic [LEN_DATA-1:0] mem_dina,
  output logic                mem_enb,
  output logic [LEN_ADDR-1:0] mem_addrb,
  input  logic [LEN_DATA-1:0] mem_doutb
);

  localparam int DEPTH = 2 ** LEN_ADDR;
  localparam logic [LEN_ADDR-1:0] CNT_LAST = LEN_ADDR'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_FLUSH
  } state_t;

  state_t                state_q;
  logic [LEN_ADDR-1:0]   cnt_q;
  logic                  rd_valid_q;
  logic                  fwd_q;       // response comes from fwd_data_q
  logic                  zero_q;      // response is forced to zero (read while busy)
  logic [LEN_DATA-1:0]   fwd_data_q;

  logic                  sweeping;
  logic                  fwd_hit;

  assign sweeping = (state_q != ST_IDLE);
  assign busy     = sweeping;

  // A write is accepted only while idle. A same-address read in that cycle
  // sees the new data.
  assign fwd_hit  = !sweeping && usr_we && usr_re && (usr_raddr == usr_waddr);

  // Sweep controller and read-response flags. Reset leaves zero_q set, so
  // rd_data reads as zero while rst is held.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      rd_valid_q <= usr_re;
      fwd_q      <= fwd_hit;
      zero_q     <= sweeping;

      unique case (state_q)
        ST_INIT, ST_FLUSH: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Forwarded data is qualified by fwd_q, so it needs no reset.
  // NOTE: pure datapath registers are left unreset. Their value is never
  // observed until a flag that is reset selects them.
  always_ff @(posedge clk) begin
    fwd_data_q <= usr_wdata;
  end

  // Write port: the sweep owns it while busy, the user owns it while idle.
  // NOTE: every output gets a default first, so no path infers a latch.
  always_comb begin
    mem_ena   = 1'b1;
    mem_wea   = 1'b1;
    mem_addra = cnt_q;
    mem_dina  = '0;
    if (!sweeping) begin
      mem_ena   = usr_we;
      mem_wea   = usr_we;
      mem_addra = usr_waddr;
      mem_dina  = usr_wdata;
    end
  end

  // The read port is always driven straight from the user.
  assign mem_enb   = usr_re;
  assign mem_addrb = usr_raddr;

  // Zero beats forward, and forward beats RAM data.
  always_comb begin
    rd_data = mem_doutb;
    if (zero_q) begin
      rd_data = '0;
    end else if (fwd_q) begin
      rd_data = fwd_data_q;
    end
  end

  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_bram_flush_writer.sv
module tb_bram_flush_writer;

  localparam int LD = 20;
  localparam int LA = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req;
  logic          busy;
  logic          usr_we;
  logic [LA-1:0] usr_waddr;
  logic [LD-1:0] usr_wdata;
  logic          usr_re;
  logic [LA-1:0] usr_raddr;
  logic          rd_valid;
  logic [LD-1:0] rd_data;
  logic          mem_ena, mem_wea, mem_enb;
  logic [LA-1:0] mem_addra, mem_addrb;
  logic [LD-1:0] mem_dina, mem_doutb;

  int checks = 0;
  int errors = 0;

  // Logical memory contents as a user should see them.
  logic [LD-1:0] ref_mem [DEPTH];

  // External block RAM: read-first, 1-cycle registered read.
  logic [LD-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_ena && mem_wea) bram[mem_addra] <= mem_dina;
    if (mem_enb) mem_doutb <= bram[mem_addrb];
  end

  always #5 clk = ~clk;

  bram_flush_writer #(.LEN_DATA(LD), .LEN_ADDR(LA)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_req (flush_req),
    .busy      (busy),
    .usr_we    (usr_we),
    .usr_waddr (usr_waddr),
    .usr_wdata (usr_wdata),
    .usr_re    (usr_re),
    .usr_raddr (usr_raddr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_ena   (mem_ena),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_enb   (mem_enb),
    .mem_addrb (mem_addrb),
    .mem_doutb (mem_doutb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic idle_inputs();
    flush_req = 1'b0;
    usr_we    = 1'b0;
    usr_re    = 1'b0;
    usr_waddr = '0;
    usr_raddr = '0;
    usr_wdata = '0;
  endtask

  // Runs one full sweep while checking the write-port address stream and the
  // total length. Garbage writes are presented meanwhile and must be dropped.
  task automatic run_sweep(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      usr_we    = 1'b1;
      usr_waddr = LA'($urandom_range(0, DEPTH - 1));
      usr_wdata = LD'($urandom);
      #1;
      checks++;
      if (mem_addra !== LA'(n) || mem_dina !== '0 || mem_ena !== 1'b1 || mem_wea !== 1'b1) begin
        errors++;
        $display("FAIL %s_addr n=%0d got addra=%0d dina=%h ena=%b wea=%b want addra=%0d dina=0 ena=1 wea=1",
                 tag, n, mem_addra, mem_dina, mem_ena, mem_wea, n % DEPTH);
      end
      step();
      n++;
    end
    idle_inputs();
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL %s_len got %0d want %0d", tag, n, DEPTH);
    end
    clear_ref();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    usr_re    = 1'b1;
    usr_raddr = 4'd9;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_out got busy=%b rd_valid=%b rd_data=%h want 1 0 0", busy, rd_valid, rd_data);
    end
    checks++;
    if (mem_ena !== 1'b1 || mem_wea !== 1'b1 || mem_addra !== '0 || mem_dina !== '0) begin
      errors++;
      $display("FAIL reset_wport got ena=%b wea=%b addra=%0d dina=%h want 1 1 0 0",
               mem_ena, mem_wea, mem_addra, mem_dina);
    end
    checks++;
    if (mem_enb !== 1'b1 || mem_addrb !== 4'd9) begin
      errors++;
      $display("FAIL reset_rport got enb=%b addrb=%0d want 1 9", mem_enb, mem_addrb);
    end
    usr_re = 1'b0;
    rst = 1'b0;
    run_sweep("init");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done got busy=%b want 0", busy);
    end
  endtask

  task automatic test_write_read();
    usr_we = 1'b1; usr_waddr = 4'd3; usr_wdata = 20'h12345;
    step();
    ref_mem[3] = 20'h12345;
    idle_inputs();
    usr_re = 1'b1; usr_raddr = 4'd3;
    step();
    idle_inputs();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[3]) begin
      errors++;
      $display("FAIL write_read got valid=%b data=%h want 1 %h", rd_valid, rd_data, ref_mem[3]);
    end
  endtask

  task automatic test_forward();
    usr_we = 1'b1; usr_waddr = 4'd5; usr_wdata = 20'hABCDE;
    usr_re = 1'b1; usr_raddr = 4'd5;
    step();
    ref_mem[5] = 20'hABCDE;
    idle_inputs();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 20'hABCDE) begin
      errors++;
      $display("FAIL forward got valid=%b data=%h want 1 abcde", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    logic          re, we;
    logic [LA-1:0] ra, wa;
    logic [LD-1:0] wd, exp;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      re = 1'($urandom);
      // Narrow address range to provoke frequent same-address collisions.
      wa = LA'($urandom_range(0, 5));
      ra = LA'($urandom_range(0, 5));
      wd = LD'($urandom);
      usr_we = we; usr_waddr = wa; usr_wdata = wd;
      usr_re = re; usr_raddr = ra;
      exp = (we && ra == wa) ? wd : ref_mem[ra];
      #1;
      checks++;
      if (mem_ena !== we || mem_wea !== we || (we && (mem_addra !== wa || mem_dina !== wd)) ||
          mem_enb !== re || mem_addrb !== ra) begin
        errors++;
        $display("FAIL rand_ports i=%0d got ena=%b addra=%0d dina=%h enb=%b addrb=%0d want ena=%b addra=%0d dina=%h enb=%b addrb=%0d",
                 i, mem_ena, mem_addra, mem_dina, mem_enb, mem_addrb, we, wa, wd, re, ra);
      end
      step();
      if (we) ref_mem[wa] = wd;
      checks++;
      if (rd_valid !== re || (re && rd_data !== exp)) begin
        errors++;
        $display("FAIL rand_read i=%0d got valid=%b data=%h want valid=%b data=%h", i, rd_valid, rd_data, re, exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int n = 0;
    logic prev_re;
    usr_we = 1'b1; usr_waddr = 4'd2; usr_wdata = 20'h0F0F0;
    step();
    ref_mem[2] = 20'h0F0F0;
    // Flush request together with a write that must still reach the RAM.
    flush_req = 1'b1;
    usr_we = 1'b1; usr_waddr = 4'd7; usr_wdata = 20'h55555;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_ena !== 1'b1 || mem_addra !== 4'd7 || mem_dina !== 20'h55555) begin
      errors++;
      $display("FAIL flush_wr got busy=%b ena=%b addra=%0d dina=%h want 0 1 7 55555", busy, mem_ena, mem_addra, mem_dina);
    end
    step();
    idle_inputs();
    prev_re = 1'b0;
    while (busy && n < 40) begin
      usr_we    = (n == 2);
      usr_waddr = 4'd2;
      usr_wdata = 20'hFFFFF;
      usr_re    = (n == 3 || n == 10);
      usr_raddr = (n == 3) ? 4'd7 : 4'd2;
      flush_req = (n == 8);
      #1;
      checks++;
      if (mem_addra !== LA'(n) || mem_dina !== '0 || mem_ena !== 1'b1) begin
        errors++;
        $display("FAIL flush_addr n=%0d got addra=%0d dina=%h ena=%b want %0d 0 1", n, mem_addra, mem_dina, mem_ena, n % DEPTH);
      end
      prev_re = usr_re;
      step();
      if (prev_re) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== '0) begin
          errors++;
          $display("FAIL flush_busy_read n=%0d got valid=%b data=%h want 1 0", n, rd_valid, rd_data);
        end
      end
      n++;
    end
    idle_inputs();
    clear_ref();
    checks++;
    if (n !== DEPTH || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_len got %0d busy=%b want %0d busy=0", n, busy, DEPTH);
    end
    // Back-to-back reads after the sweep.
    usr_re = 1'b1; usr_raddr = 4'd7;
    step();
    usr_raddr = 4'd2;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[7]) begin
      errors++;
      $display("FAIL flush_rd7 got valid=%b data=%h want 1 %h", rd_valid, rd_data, ref_mem[7]);
    end
    step();
    idle_inputs();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[2]) begin
      errors++;
      $display("FAIL flush_rd2 got valid=%b data=%h want 1 %h", rd_valid, rd_data, ref_mem[2]);
    end
  endtask

  task automatic test_reset_mid_flush();
    usr_we = 1'b1; usr_waddr = 4'd11; usr_wdata = 20'h3C3C3;
    step();
    ref_mem[11] = 20'h3C3C3;
    idle_inputs();
    flush_req = 1'b1;
    step();
    idle_inputs();
    for (int k = 0; k < 9; k++) begin
      usr_re = (k == 8); usr_raddr = 4'd11;
      step();
    end
    usr_re = 1'b0;
    checks++;
    if (mem_addra !== 4'd9 || rd_valid !== 1'b1 || rd_data !== '0) begin
      errors++;
      $display("FAIL midrst_pre got addra=%0d valid=%b data=%h want 9 1 0", mem_addra, rd_valid, rd_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || mem_addra !== '0) begin
      errors++;
      $display("FAIL midrst_out got busy=%b valid=%b data=%h addra=%0d want 1 0 0 0", busy, rd_valid, rd_data, mem_addra);
    end
    step();
    rst = 1'b0;
    run_sweep("midrst");
    usr_re = 1'b1; usr_raddr = 4'd11;
    step();
    idle_inputs();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[11]) begin
      errors++;
      $display("FAIL midrst_rd got valid=%b data=%h want 1 %h", rd_valid, rd_data, ref_mem[11]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_ref();
    test_reset();
    test_write_read();
    test_forward();
    test_random();
    test_flush();
    test_random();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
